// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register-file port controller:
//   - default address/data widths for the 16 x 32-bit register file
//   - controller state encoding
//   - transaction kind (read of two operands / write of one destination)
//   - small helper used to decode "a register-file transaction is in flight"
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;

    // Controller states. Exactly one register-file transaction is ever in
    // flight; the states walk it from issue to completion.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,  // ready for a writeback or an operand read
        ISSUE     = 3'd1,  // waiting for rf_busy low, then pulse rf_enable
        WAIT_ACK  = 3'd2,  // the cycle where rf_busy must have risen
        WAIT_DONE = 3'd3,  // waiting for rf_busy to fall
        RSP       = 3'd4   // operands held until the consumer takes them
    } state_t;

    // Kind of the transaction currently latched in the controller.
    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_kind_t;

    // True while the register file owns the latched transaction, i.e. from
    // the issue cycle up to and including the completion cycle.
    function automatic logic rf_txn_active(input state_t s);
        return (s == ISSUE) || (s == WAIT_ACK) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_port_ctrl_if
//   Pipeline-facing handshakes of the register-file port controller.
//
//   Operand read request  : rd_req_valid / rd_req_ready, rd_req_rs1, rd_req_rs2
//   Operand read response : rd_rsp_valid / rd_rsp_ready, rd_rsp_rs1data,
//                           rd_rsp_rs2data
//   Writeback request     : wb_valid / wb_ready, wb_rdadr, wb_data
//
//   master : the core pipeline (decode, consumer, writeback stage)
//   slave  : the controller
// -----------------------------------------------------------------------------
interface regfile_port_ctrl_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_rs1;
    logic [ADDR_W-1:0] rd_req_rs2;

    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_rs1data;
    logic [DATA_W-1:0] rd_rsp_rs2data;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rdadr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output rd_req_valid, rd_req_rs1, rd_req_rs2,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_rs1data, rd_rsp_rs2data,
        output rd_rsp_ready,
        output wb_valid, wb_rdadr, wb_data,
        input  wb_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_rs1, rd_req_rs2,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_rs1data, rd_rsp_rs2data,
        input  rd_rsp_ready,
        input  wb_valid, wb_rdadr, wb_data,
        output wb_ready
    );

endinterface

// File: rtl/regfile_port_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_port_ctrl
//   Initiator-side controller for the byte-serialized SRAM register file.
//   Accepts operand reads and writebacks from the pipeline, runs exactly one
//   enable/busy transaction at a time against the register file and holds the
//   read operands until the consumer takes them.
//
// Ports
//   clk           core clock
//   reset         synchronous, active-low reset
//   bus           pipeline handshakes (regfile_port_ctrl_if.slave)
//   rf_enable     one-cycle start pulse to the register file
//   rf_regwrite   write select, high from issue to completion of writes only
//   rf_rs1adr     source 1 address, held for the transaction
//   rf_rs2adr     source 2 address, held for the transaction
//   rf_rdadr      destination address, held for the transaction
//   rf_rd         write data, held for the transaction
//   rf_rs1/rf_rs2 register file read data
//   rf_busy       register file busy
//   protocol_err  sticky: rf_busy did not rise the cycle after rf_enable
// -----------------------------------------------------------------------------
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    regfile_port_ctrl_if.slave  bus,

    output logic                rf_enable,
    output logic                rf_regwrite,
    output logic [ADDR_W-1:0]   rf_rs1adr,
    output logic [ADDR_W-1:0]   rf_rs2adr,
    output logic [ADDR_W-1:0]   rf_rdadr,
    output logic [DATA_W-1:0]   rf_rd,
    input  logic [DATA_W-1:0]   rf_rs1,
    input  logic [DATA_W-1:0]   rf_rs2,
    input  logic                rf_busy,

    output logic                protocol_err
);

    state_t            state;
    state_t            state_nxt;
    txn_kind_t         kind;

    logic [ADDR_W-1:0] rs1_adr_q;
    logic [ADDR_W-1:0] rs2_adr_q;
    logic [ADDR_W-1:0] rd_adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic              err_q;

    // One-cycle strobes decoded by the FSM and consumed by the holding
    // registers.
    logic              accept_wb;
    logic              accept_rd;
    logic              capture;
    logic              set_err;

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case so that
    // no path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_nxt        = state;
        bus.wb_ready     = 1'b0;
        bus.rd_req_ready = 1'b0;
        rf_enable        = 1'b0;
        accept_wb        = 1'b0;
        accept_rd        = 1'b0;
        capture          = 1'b0;
        set_err          = 1'b0;

        unique case (state)
            IDLE: begin
                // Writeback has priority: a pending writeback hides the read
                // port, so a read is never accepted in the same cycle.
                bus.wb_ready     = 1'b1;
                bus.rd_req_ready = !bus.wb_valid;
                if (bus.wb_valid) begin
                    accept_wb = 1'b1;
                    // x0 is hardwired to zero: the write is acknowledged but
                    // never reaches the register file.
                    if (bus.wb_rdadr != '0) begin
                        state_nxt = ISSUE;
                    end
                end else if (bus.rd_req_valid) begin
                    accept_rd = 1'b1;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                // Only start when the register file is free; it may still be
                // finishing a transaction that a reset abandoned.
                if (!rf_busy) begin
                    rf_enable = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // Busy must be up by now. Record the violation but keep going
                // so the pipeline is not wedged by a misbehaving file.
                set_err   = !rf_busy;
                state_nxt = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (!rf_busy) begin
                    if (kind == TXN_READ) begin
                        capture   = 1'b1;
                        state_nxt = RSP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            RSP: begin
                if (bus.rd_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Holding registers
    // -------------------------------------------------------------------------
    // NOTE: these are a handful of flops, not a RAM, so clearing them on reset
    // is cheap and gives the register-file address/data pins a known value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kind       <= TXN_READ;
            rs1_adr_q  <= '0;
            rs2_adr_q  <= '0;
            rd_adr_q   <= '0;
            wdata_q    <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept_wb) begin
                kind     <= TXN_WRITE;
                rd_adr_q <= bus.wb_rdadr;
                wdata_q  <= bus.wb_data;
            end
            if (accept_rd) begin
                kind      <= TXN_READ;
                rs1_adr_q <= bus.rd_req_rs1;
                rs2_adr_q <= bus.rd_req_rs2;
            end
            if (capture) begin
                rs1_data_q <= rf_rs1;
                rs2_data_q <= rf_rs2;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // rf_regwrite directly gates the SRAM write strobe, so it is decoded from
    // the registered state and kind only and can never glitch high on a read.
    assign rf_regwrite = (kind == TXN_WRITE) && rf_txn_active(state);

    // Register-file pins come from the latched request, never from the ports.
    assign rf_rs1adr = rs1_adr_q;
    assign rf_rs2adr = rs2_adr_q;
    assign rf_rdadr  = rd_adr_q;
    assign rf_rd     = wdata_q;

    assign bus.rd_rsp_valid   = (state == RSP);
    assign bus.rd_rsp_rs1data = rs1_data_q;
    assign bus.rd_rsp_rs2data = rs2_data_q;

    assign protocol_err = err_q;

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Initiator-side controller for the byte-serialized SRAM register file (enable/busy protocol).
- Accepts operand-read requests from decode and writeback requests from the execute/writeback stage over valid/ready handshakes.
- Sequences exactly one register-file transaction at a time and holds the operands until the consumer takes them.
- Sits between the core pipeline and the register file; it is the only driver of the register file's control inputs.

Parameters:
- ADDR_W, 4, register address width (16 registers).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when high together with valid.
- rd_req_rs1  in  ADDR_W  source register 1 address.
- rd_req_rs2  in  ADDR_W  source register 2 address.
- rd_rsp_valid  out  1  operands valid.
- rd_rsp_ready  in  1  consumer takes the operands.
- rd_rsp_rs1data  out  DATA_W  operand 1.
- rd_rsp_rs2data  out  DATA_W  operand 2.
- wb_valid  in  1  writeback request valid.
- wb_ready  out  1  writeback accepted.
- wb_rdadr  in  ADDR_W  destination register address.
- wb_data  in  DATA_W  writeback data.
- rf_enable  out  1  one-cycle start pulse to the register file.
- rf_regwrite  out  1  write select; high only during a write transaction.
- rf_rs1adr, rf_rs2adr, rf_rdadr  out  ADDR_W  register file addresses, held for the whole transaction.
- rf_rd  out  DATA_W  write data, held for the whole transaction.
- rf_rs1, rf_rs2  in  DATA_W  register file read outputs.
- rf_busy  in  1  register file busy.
- protocol_err  out  1  sticky; set when rf_busy fails to rise after rf_enable.

Behaviour:
- Reset is synchronous and takes effect while reset==0.
  - State goes to IDLE; rd_rsp_valid, rf_enable, rf_regwrite and protocol_err go to 0.
  - Latched addresses, data and operands go to 0.
  - Any in-flight transaction is discarded; no response is produced for it.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RSP.
- IDLE:
  - wb_ready=1 and rd_req_ready=1, except that rd_req_ready=0 whenever wb_valid=1, so writeback has priority.
  - On acceptance, latch the request addresses and data and go to ISSUE.
  - Accepted write with wb_rdadr==0: complete immediately with no register file transaction; stay in IDLE.
- ISSUE:
  - rf_enable=1 only when rf_busy==0; otherwise wait in ISSUE.
  - After the pulse, go to WAIT_ACK.
- WAIT_ACK, one cycle:
  - Expect rf_busy==1.
  - If rf_busy==0, set protocol_err and still go to WAIT_DONE.
- WAIT_DONE:
  - Wait for rf_busy==0.
  - Read transaction: capture rf_rs1/rf_rs2 into the output registers and go to RSP.
  - Write transaction: return to IDLE.
- RSP:
  - rd_rsp_valid=1; operands stay stable until rd_rsp_ready.
  - On handshake, return to IDLE. No new request is accepted while in RSP.
- rf_regwrite:
  - Held at 1 from ISSUE through WAIT_DONE, for writes only.
  - 0 in every other state and for all reads. It must be low during reads because it directly gates the SRAM write.
- rf_*adr and rf_rd are driven from the latched values from ISSUE through the capture cycle. They are never combinational from the request ports.
- Read latency:
  - Accept at cycle T; rf_enable at T+1; rf_busy high T+2..T+11; capture at T+12; rd_rsp_valid at T+13.
  - With rd_rsp_ready held high, the next request is accepted at T+14.
- Write latency: accept at T; rf_busy high T+2..T+6; IDLE at T+8.
- Register x0:
  - Reads of x0 return 0; the register file masks them.
  - rs1==rs2 is legal and returns equal operands.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W defaults.
  - The state enum typedef.
  - The read/write transaction-kind typedef.
- No sub-module is needed; the block is a single FSM plus holding registers.

Test Plan:
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> rs1data=0xDEADBEEF, rs2data=0; rd_rsp_valid exactly 13 cycles after read acceptance.
- Write x0=0x12345678 -> wb_ready handshake only; rf_enable never pulses; a later read of x0 returns 0.
- wb_valid and rd_req_valid both high in IDLE, write x3=0xA5A5A5A5 and read rs1=3, rs2=3 -> write handled first; read returns 0xA5A5A5A5 on both operands.
- Read completes with rd_rsp_ready held low 20 cycles -> rd_rsp_valid and data stable; rd_req_ready and wb_ready stay 0; rf_enable stays 0.
- Assert reset in cycle T+5 of a read -> next cycle IDLE, rd_rsp_valid=0, rf_regwrite=0; a following write/read pair returns correct data.
- Register file stub holds rf_busy=0 after rf_enable -> protocol_err=1 and stays set until reset.
